// File: rtl/train_route_sequencer.sv
// Route phase sequencer: steps Selector through 16 phases, debounces Y to advance,
// drives the TIMER dwell flag for timed phases and latches a watchdog fault.
module train_route_sequencer #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned DEBOUNCE     = 4,
    parameter int unsigned TIMEOUT      = 500_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Fault_Clr,
    input  logic       Y,
    output logic [3:0] Selector,
    output logic       Enable,
    output logic       TIMER,
    output logic       Phase_Done,
    output logic       Lap,
    output logic       Busy,
    output logic       Fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_ADVANCE,
        S_FAULT
    } state_t;

    localparam logic [31:0] DWELL_LAST   = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [7:0]  DEB_LIMIT    = 8'(DEBOUNCE);

    state_t      state_q, state_d;
    logic [3:0]  selector_q, selector_d;
    logic        enable_q, enable_d;
    logic        timer_q, timer_d;
    logic        phase_done_q, phase_done_d;
    logic        lap_q, lap_d;
    logic        busy_q, busy_d;
    logic        fault_q, fault_d;
    logic [31:0] dwell_q, dwell_d;
    logic [7:0]  deb_q, deb_d;
    logic [31:0] wd_q, wd_d;

    logic        timed_phase;
    logic        wd_expire;
    logic        deb_done;
    logic [7:0]  deb_inc;

    assign timed_phase = (selector_q >= 4'd2) && (selector_q <= 4'd5);
    assign deb_inc     = deb_q + 8'd1;

    // All *_d values describe the state being entered, so outputs stay registered.
    always_comb begin
        state_d      = state_q;
        selector_d   = selector_q;
        enable_d     = 1'b0;
        timer_d      = 1'b0;
        phase_done_d = 1'b0;
        lap_d        = 1'b0;
        busy_d       = 1'b0;
        fault_d      = 1'b0;
        dwell_d      = dwell_q;
        deb_d        = deb_q;
        wd_d         = wd_q;
        wd_expire    = 1'b0;
        deb_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                selector_d = 4'd0;
                dwell_d    = '0;
                deb_d      = '0;
                wd_d       = '0;
                if (Start) begin
                    state_d  = S_ARM;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            S_ARM: begin
                dwell_d = '0;
                deb_d   = '0;
                wd_d    = '0;
                busy_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy_d   = 1'b1;
                deb_d    = Y ? deb_inc : 8'd0;
                deb_done = Y && (deb_inc == DEB_LIMIT);
                if (timed_phase) begin
                    dwell_d = dwell_q + 32'd1;
                    timer_d = timer_q | (dwell_q == DWELL_LAST);
                end else begin
                    wd_d      = wd_q + 32'd1;
                    wd_expire = (wd_q == TIMEOUT_LAST);
                end
                if (wd_expire) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                    timer_d = 1'b0;
                end else if (deb_done) begin
                    state_d      = S_ADVANCE;
                    phase_done_d = 1'b1;
                    lap_d        = (selector_q == 4'd15);
                end
            end
            S_ADVANCE: begin
                state_d    = S_ARM;
                selector_d = selector_q + 4'd1;
                enable_d   = 1'b1;
                busy_d     = 1'b1;
            end
            S_FAULT: begin
                fault_d = 1'b1;
                if (Fault_Clr) begin
                    state_d    = S_IDLE;
                    fault_d    = 1'b0;
                    selector_d = 4'd0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                selector_d = 4'd0;
            end
        endcase

        // Stop outranks everything but FAULT; in IDLE it also masks Start.
        if (Stop && (state_q != S_FAULT)) begin
            state_d      = S_IDLE;
            selector_d   = 4'd0;
            enable_d     = 1'b0;
            timer_d      = 1'b0;
            phase_done_d = 1'b0;
            lap_d        = 1'b0;
            busy_d       = 1'b0;
            fault_d      = 1'b0;
            dwell_d      = '0;
            deb_d        = '0;
            wd_d         = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            selector_q   <= '0;
            enable_q     <= 1'b0;
            timer_q      <= 1'b0;
            phase_done_q <= 1'b0;
            lap_q        <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            dwell_q      <= '0;
            deb_q        <= '0;
            wd_q         <= '0;
        end else begin
            state_q      <= state_d;
            selector_q   <= selector_d;
            enable_q     <= enable_d;
            timer_q      <= timer_d;
            phase_done_q <= phase_done_d;
            lap_q        <= lap_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            dwell_q      <= dwell_d;
            deb_q        <= deb_d;
            wd_q         <= wd_d;
        end
    end

    assign Selector   = selector_q;
    assign Enable     = enable_q;
    assign TIMER      = timer_q;
    assign Phase_Done = phase_done_q;
    assign Lap        = lap_q;
    assign Busy       = busy_q;
    assign Fault      = fault_q;

endmodule

// File: doc/train_route_sequencer.md
# train_route_sequencer

Sequencing controller for the track-condition syncronizer. It steps the 4-bit `Selector` through the 16 route phases (0 to 15, wrapping) and pulses `Enable` at each phase entry. It generates the `TIMER` dwell signal for timed phases 2 to 5, and advances to the next phase once the syncronizer's `Y` output has been stable high for a debounce window. A watchdog forces a latched fault if a sensor phase never completes.

## Interface
- `DWELL_CYCLES`, default 50_000_000: timed-phase dwell length in clocks (1 s at 50 MHz); legal range 1 to 2^32-1.
- `DEBOUNCE`, default 4: number of consecutive high samples of `Y` required to advance; legal range 1 to 255.
- `TIMEOUT`, default 500_000_000: watchdog limit in clocks for sensor phases; legal range 1 to 2^32-1.
- `CLK` input 1: the single clock; all state changes on its rising edge.
- `RESET` input 1: reset is synchronous and active-high.
- `Start` input 1: begin a route at phase 0; honoured only in IDLE.
- `Stop` input 1: abort to IDLE from any state except FAULT.
- `Fault_Clr` input 1: leave FAULT for IDLE.
- `Y` input 1: condition result returned by the syncronizer.
- `Selector` output 4: current phase, fed to the syncronizer.
- `Enable` output 1: one-cycle pulse at each phase entry.
- `TIMER` output 1: dwell-expired flag, fed to the syncronizer.
- `Phase_Done` output 1: one-cycle pulse when a phase completes.
- `Lap` output 1: one-cycle pulse when phase 15 completes.
- `Busy` output 1: high in ARM, WAIT and ADVANCE.
- `Fault` output 1: high in FAULT.

## Operation
- States: IDLE, ARM, WAIT, ADVANCE, FAULT. All outputs are registered.
- Reset values: state IDLE; every output and every counter 0.
- Priority, checked each cycle: `RESET` > `Stop` > watchdog expiry > debounce completion > `Start`.
- IDLE
  - `Selector` = 0.
  - `Start`=1 moves to ARM with phase 0.
- ARM (one cycle)
  - `Enable`=1 and `TIMER`=0.
  - Dwell, debounce and watchdog counters clear to 0.
  - Next state is WAIT.
- WAIT, timed phases (`Selector` 2 to 5)
  - The 32-bit dwell counter increments.
  - When the count equals `DWELL_CYCLES`-1, `TIMER` is set on the following edge.
  - `TIMER` then holds 1 until the phase exits.
  - The watchdog is disabled.
- WAIT, sensor phases (all others)
  - The 32-bit watchdog counter increments.
  - When the count equals `TIMEOUT`-1, the next state is FAULT.
  - `TIMER` stays 0.
- Debounce, all phases
  - The 8-bit counter increments while `Y`=1 and clears to 0 on `Y`=0.
  - When it reaches `DEBOUNCE`, the next state is ADVANCE.
  - If watchdog expiry and debounce completion fall on the same edge, FAULT wins.
- ADVANCE (one cycle)
  - `Phase_Done`=1.
  - `Selector` increments modulo 16 on the exit edge.
  - `Lap`=1 in this cycle if `Selector` was 15, so 15 wraps to 0.
  - Next state is ARM.
- FAULT
  - `Fault`=1 and `TIMER`=0.
  - `Selector` holds the faulting phase.
  - `Start` and `Stop` are ignored.
  - `Fault_Clr`=1 moves to IDLE, which resets `Selector` to 0.
- Stop: any state other than IDLE or FAULT goes to IDLE on the next edge, clearing all counters and pulses.
- Start: ignored in every state except IDLE. Holding it high does not restart a running route.
- Reset mid-route: IDLE on the next edge, with all outputs 0.

## Timing
- `Start` sampled at edge n:
  - ARM at n+1, with `Enable` high during cycle n+1.
  - WAIT from n+2.
- `Y` high continuously from the first WAIT cycle k: ADVANCE occurs at cycle k+`DEBOUNCE`.
- Minimum phase period is `DEBOUNCE`+2 cycles (ARM, debounce window, ADVANCE).
- New `Selector` is valid in the ARM cycle that `Enable` marks. The syncronizer is combinational, so `Y` for the new phase is valid that same cycle.
- Timed-phase latency:
  - `TIMER` rises at WAIT cycle `DWELL_CYCLES`.
  - `Y` then follows `TIMER`, so ADVANCE comes `DEBOUNCE` cycles later.
- Watchdog: FAULT is entered `TIMEOUT` cycles after WAIT entry if no debounced `Y` arrives.
- A `Y` glitch shorter than `DEBOUNCE` cycles never advances the phase.

## Test plan
- Basic advance, with `DEBOUNCE`=4 and `Y` tied high:
  - Pulse `Start`.
  - Required: `Enable` one cycle later, `Phase_Done` 5 cycles after `Enable`, then `Selector` 0→1.
- Timed phase, with `DWELL_CYCLES`=10 and `Y` driven by the `TIMER` loopback:
  - Required at `Selector`=2: `TIMER` rises on WAIT cycle 10, `Phase_Done` 4 cycles later, `TIMER` back to 0 in the next ARM.
- Debounce:
  - At `Selector`=0, pulse `Y` high for 3 cycles, low for 1, then high for 4.
  - Required: exactly one `Phase_Done`, after the second burst.
- Wrap and lap, with `Y` tied high and `DWELL_CYCLES`=1:
  - Run 16 phases.
  - Required: `Lap` pulses with `Phase_Done` at `Selector`=15, then `Selector`=0 with `Enable`.
- Watchdog and fault, with `TIMEOUT`=20 and `Y`=0 at `Selector`=0:
  - Required: `Fault`=1 after 20 WAIT cycles, and `Start` ignored while faulted.
  - Then `Fault_Clr`: required `Fault`=0, `Busy`=0, `Selector`=0.
- Stop and reset mid-route:
  - Assert `Stop` during WAIT at `Selector`=6. Required: IDLE next cycle with `Selector`=0 and no `Phase_Done`.
  - Repeat with `RESET` instead. Required: the same result, with all outputs 0.
